// File: rtl/mux_switch_pkg.sv
// -----------------------------------------------------------------------------
// mux_switch_pkg
// Shared definitions for the glitch-safe N:1 switch mux:
//   - mux_state_e : switch FSM state encoding
//   - GAP_CNT_W   : width of the blanking gap counter
//   - clog2_f     : ceil(log2) helper used to size select fields
// -----------------------------------------------------------------------------
package mux_switch_pkg;

    localparam int GAP_CNT_W = 4;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        BLANK  = 2'd1,
        SWITCH = 2'd2
    } mux_state_e;

    // Smallest number of bits able to index 'value' distinct items.
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_nx1_switch_if.sv
// -----------------------------------------------------------------------------
// mux_nx1_switch_if
// Data and select-handshake bundle of mux_nx1_switch.
//   Data_In   : CHANNELS*WIDTH packed channels, channel k at [k*WIDTH +: WIDTH]
//   Sel_Req   : single-cycle select-change request
//   Sel_In    : requested channel
//   Sel_Lock  : (only with MUX_SEL_LOCK_EN) reject every request while high
//   Sel_Busy  : switch in progress
//   Sel_Ack   : one-cycle pulse, new select in effect
//   Sel_Err   : one-cycle pulse, request rejected
//   Cur_Sel   : channel currently routed
//   Mux_Out   : registered output data
//   Out_Valid : Mux_Out carries channel data
// Modports: master (request side), slave (the mux).
// -----------------------------------------------------------------------------
interface mux_nx1_switch_if
    import mux_switch_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = clog2_f(CHANNELS)
);
    logic [CHANNELS*WIDTH-1:0] Data_In;
    logic                      Sel_Req;
    logic [SEL_W-1:0]          Sel_In;
`ifdef MUX_SEL_LOCK_EN
    logic                      Sel_Lock;
`endif
    logic                      Sel_Busy;
    logic                      Sel_Ack;
    logic                      Sel_Err;
    logic [SEL_W-1:0]          Cur_Sel;
    logic [WIDTH-1:0]          Mux_Out;
    logic                      Out_Valid;

    modport master (
        output Data_In, Sel_Req, Sel_In,
`ifdef MUX_SEL_LOCK_EN
        output Sel_Lock,
`endif
        input  Sel_Busy, Sel_Ack, Sel_Err, Cur_Sel, Mux_Out, Out_Valid
    );

    modport slave (
        input  Data_In, Sel_Req, Sel_In,
`ifdef MUX_SEL_LOCK_EN
        input  Sel_Lock,
`endif
        output Sel_Busy, Sel_Ack, Sel_Err, Cur_Sel, Mux_Out, Out_Valid
    );

endinterface

// File: rtl/mux_nx1_core.sv
// -----------------------------------------------------------------------------
// mux_nx1_core
// Purely combinational WIDTH x CHANNELS selector.
//   data_in  : packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel      : channel index
//   data_out : selected channel (all zeros for an index >= CHANNELS)
// -----------------------------------------------------------------------------
module mux_nx1_core #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          data_out
);

    // Compare-and-pick loop keeps every part-select in range for any sel value.
    always_comb begin
        data_out = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            data_out = (sel == SEL_W'(k)) ? data_in[k*WIDTH +: WIDTH] : data_out;
        end
    end

endmodule

// File: rtl/mux_nx1_switch.sv
// -----------------------------------------------------------------------------
// mux_nx1_switch
// Parametrised N:1 registered mux with request/acknowledge select switching
// and a programmable blanking gap, so a consumer never sees a partial switch.
// Ports:
//   CLK : system clock
//   RST : synchronous active-high reset
//   bus : mux_nx1_switch_if.slave (data, select handshake, output)
// Optional build macro MUX_SEL_LOCK_EN adds Sel_Lock to the interface; while it
// is high in ACTIVE every request is rejected with Sel_Err.
// -----------------------------------------------------------------------------
module mux_nx1_switch
    import mux_switch_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               CHANNELS = 4,
    parameter int               GAP      = 2,
    parameter int               RST_SEL  = 0,
    parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    mux_nx1_switch_if.slave      bus
);

    localparam int SEL_W = clog2_f(CHANNELS);
    localparam bit GAP_EN = (GAP > 0);
    localparam logic [GAP_CNT_W-1:0] GAP_M1 = GAP_EN ? GAP_CNT_W'(GAP - 1) : '0;
    localparam logic [SEL_W:0]       SEL_LIM = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0]     RST_SEL_V = SEL_W'(RST_SEL);

    mux_state_e             state_r;
    logic [GAP_CNT_W-1:0]   gap_cnt_r;
    logic [SEL_W-1:0]       pend_sel_r;
    logic [SEL_W-1:0]       cur_sel_r;
    logic [WIDTH-1:0]       mux_out_r;
    logic                   out_valid_r;
    logic                   busy_r;
    logic                   ack_r;
    logic                   err_r;

    logic [WIDTH-1:0]       core_out_s;
    logic                   lock_s;
    logic                   bad_sel_s;

`ifdef MUX_SEL_LOCK_EN
    assign lock_s = bus.Sel_Lock;
`else
    assign lock_s = 1'b0;
`endif

    assign bad_sel_s = ({1'b0, bus.Sel_In} >= SEL_LIM);

    mux_nx1_core #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_core (
        .data_in  (bus.Data_In),
        .sel      (cur_sel_r),
        .data_out (core_out_s)
    );

    // Switch FSM, gap counter and all registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ACTIVE;
            gap_cnt_r   <= '0;
            pend_sel_r  <= RST_SEL_V;
            cur_sel_r   <= RST_SEL_V;
            mux_out_r   <= IDLE_VAL;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            ack_r       <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            case (state_r)
                ACTIVE: begin
                    mux_out_r   <= core_out_s;
                    out_valid_r <= 1'b1;
                    busy_r      <= 1'b0;
                    if (bus.Sel_Req) begin
                        if (lock_s || bad_sel_s) begin
                            err_r <= 1'b1;
                        end else if (bus.Sel_In == cur_sel_r) begin
                            ack_r <= 1'b1;
                        end else begin
                            // Accepted: blank the output from the very next cycle.
                            pend_sel_r  <= bus.Sel_In;
                            mux_out_r   <= IDLE_VAL;
                            out_valid_r <= 1'b0;
                            busy_r      <= 1'b1;
                            if (GAP_EN) begin
                                state_r   <= BLANK;
                                gap_cnt_r <= GAP_M1;
                            end else begin
                                state_r   <= SWITCH;
                                cur_sel_r <= bus.Sel_In;
                                ack_r     <= 1'b1;
                            end
                        end
                    end else begin
                        state_r <= ACTIVE;
                    end
                end
                BLANK: begin
                    mux_out_r   <= IDLE_VAL;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b1;
                    if (gap_cnt_r == '0) begin
                        // Cur_Sel and Ack both become visible in the SWITCH cycle.
                        state_r   <= SWITCH;
                        cur_sel_r <= pend_sel_r;
                        ack_r     <= 1'b1;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
                    end
                end
                SWITCH: begin
                    // cur_sel_r already holds the new channel here.
                    state_r     <= ACTIVE;
                    mux_out_r   <= core_out_s;
                    out_valid_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r     <= ACTIVE;
                    gap_cnt_r   <= '0;
                    mux_out_r   <= IDLE_VAL;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Sel_Busy  = busy_r;
    assign bus.Sel_Ack   = ack_r;
    assign bus.Sel_Err   = err_r;
    assign bus.Cur_Sel   = cur_sel_r;
    assign bus.Mux_Out   = mux_out_r;
    assign bus.Out_Valid = out_valid_r;

endmodule

// File: tb/tb_mux_nx1_switch.sv
// -----------------------------------------------------------------------------
// tb_mux_nx1_switch
// Three instances share CLK/RST: u0 defaults (4 ch, GAP=2), u1 (3 ch) for the
// same-select / out-of-range requests, u2 (GAP=0). u0 runs a cycle table; u1,
// u2 and the optional lock feature get short hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mux_nx1_switch;
    import mux_switch_pkg::*;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    mux_nx1_switch_if #(.WIDTH(8), .CHANNELS(4)) bus0 ();
    mux_nx1_switch_if #(.WIDTH(8), .CHANNELS(3)) bus1 ();
    mux_nx1_switch_if #(.WIDTH(8), .CHANNELS(4)) bus2 ();

    mux_nx1_switch #(.WIDTH(8), .CHANNELS(4), .GAP(2)) u0 (.CLK(CLK), .RST(RST), .bus(bus0));
    mux_nx1_switch #(.WIDTH(8), .CHANNELS(3), .GAP(2)) u1 (.CLK(CLK), .RST(RST), .bus(bus1));
    mux_nx1_switch #(.WIDTH(8), .CHANNELS(4), .GAP(0)) u2 (.CLK(CLK), .RST(RST), .bus(bus2));

    // Free-running clock, period 10.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       rst;
        logic       req;
        logic [1:0] sel;
        logic [7:0] d0;
        logic [7:0] e_out;
        logic       e_val;
        logic       e_busy;
        logic       e_ack;
        logic       e_err;
        logic [1:0] e_cur;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b1;
        bus0.Sel_Req = 1'b0; bus0.Sel_In = 2'd0; bus0.Data_In = {8'h3C, 8'hC3, 8'h5A, 8'hA5};
        bus1.Sel_Req = 1'b0; bus1.Sel_In = 2'd0; bus1.Data_In = {8'h33, 8'h22, 8'h11};
        bus2.Sel_Req = 1'b0; bus2.Sel_In = 2'd0; bus2.Data_In = {8'h3C, 8'hC3, 8'h5A, 8'hA5};
`ifdef MUX_SEL_LOCK_EN
        bus0.Sel_Lock = 1'b0;
        bus1.Sel_Lock = 1'b0;
        bus2.Sel_Lock = 1'b0;
`endif

        //            rst   req   sel   d0      out    val   busy  ack   err   cur
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 2'd0, 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[3]  = '{1'b0, 1'b1, 2'd3, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[4]  = '{1'b0, 1'b0, 2'd0, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[5]  = '{1'b0, 1'b0, 2'd0, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3};
        vecs[6]  = '{1'b0, 1'b0, 2'd0, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3};
        vecs[7]  = '{1'b0, 1'b1, 2'd3, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3};
        vecs[8]  = '{1'b0, 1'b1, 2'd2, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3};
        vecs[9]  = '{1'b0, 1'b1, 2'd1, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3};
        vecs[10] = '{1'b0, 1'b0, 2'd0, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 8'hA5, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2};
        vecs[12] = '{1'b0, 1'b0, 2'd0, 8'hA5, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2};
        vecs[13] = '{1'b0, 1'b1, 2'd1, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2};
        vecs[14] = '{1'b1, 1'b1, 2'd3, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[15] = '{1'b0, 1'b0, 2'd0, 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[16] = '{1'b0, 1'b0, 2'd0, 8'h77, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};

        for (int i = 0; i < NVEC; i++) begin
            RST           = vecs[i].rst;
            bus0.Sel_Req  = vecs[i].req;
            bus0.Sel_In   = vecs[i].sel;
            bus0.Data_In  = {8'h3C, 8'hC3, 8'h5A, vecs[i].d0};
            tick();
            chk($sformatf("row%0d.out", i),  32'(bus0.Mux_Out),   32'(vecs[i].e_out));
            chk($sformatf("row%0d.val", i),  32'(bus0.Out_Valid), 32'(vecs[i].e_val));
            chk($sformatf("row%0d.busy", i), 32'(bus0.Sel_Busy),  32'(vecs[i].e_busy));
            chk($sformatf("row%0d.ack", i),  32'(bus0.Sel_Ack),   32'(vecs[i].e_ack));
            chk($sformatf("row%0d.err", i),  32'(bus0.Sel_Err),   32'(vecs[i].e_err));
            chk($sformatf("row%0d.cur", i),  32'(bus0.Cur_Sel),   32'(vecs[i].e_cur));
        end
        RST          = 1'b0;
        bus0.Sel_Req = 1'b0;
        bus0.Data_In = {8'h3C, 8'hC3, 8'h5A, 8'hA5};

        // u1 (3 channels): same-select request acks without blanking.
        bus1.Sel_Req = 1'b1; bus1.Sel_In = 2'd0;
        tick();
        bus1.Sel_Req = 1'b0;
        chk("same.ack", 32'(bus1.Sel_Ack),   32'd1);
        chk("same.err", 32'(bus1.Sel_Err),   32'd0);
        chk("same.val", 32'(bus1.Out_Valid), 32'd1);
        chk("same.out", 32'(bus1.Mux_Out),   32'h11);
        tick();
        chk("same.ack_end", 32'(bus1.Sel_Ack), 32'd0);
        // u1: channel 3 does not exist.
        bus1.Sel_Req = 1'b1; bus1.Sel_In = 2'd3;
        tick();
        bus1.Sel_Req = 1'b0;
        chk("oor.err",  32'(bus1.Sel_Err),   32'd1);
        chk("oor.ack",  32'(bus1.Sel_Ack),   32'd0);
        chk("oor.cur",  32'(bus1.Cur_Sel),   32'd0);
        chk("oor.val",  32'(bus1.Out_Valid), 32'd1);
        chk("oor.busy", 32'(bus1.Sel_Busy),  32'd0);
        tick();
        chk("oor.err_end", 32'(bus1.Sel_Err), 32'd0);
        chk("oor.out",     32'(bus1.Mux_Out), 32'h11);

        // u2 (GAP=0): exactly one blank cycle, carrying the ack.
        bus2.Sel_Req = 1'b1; bus2.Sel_In = 2'd2;
        tick();
        bus2.Sel_Req = 1'b0;
        chk("gap0.val",  32'(bus2.Out_Valid), 32'd0);
        chk("gap0.out",  32'(bus2.Mux_Out),   32'h00);
        chk("gap0.ack",  32'(bus2.Sel_Ack),   32'd1);
        chk("gap0.busy", 32'(bus2.Sel_Busy),  32'd1);
        chk("gap0.cur",  32'(bus2.Cur_Sel),   32'd2);
        tick();
        chk("gap0.val2", 32'(bus2.Out_Valid), 32'd1);
        chk("gap0.out2", 32'(bus2.Mux_Out),   32'hC3);
        chk("gap0.ack2", 32'(bus2.Sel_Ack),   32'd0);
        chk("gap0.bsy2", 32'(bus2.Sel_Busy),  32'd0);

`ifdef MUX_SEL_LOCK_EN
        // u0 locked: a valid request to channel 1 is rejected.
        bus0.Sel_Lock = 1'b1;
        bus0.Sel_Req = 1'b1; bus0.Sel_In = 2'd1;
        tick();
        chk("lock.err",  32'(bus0.Sel_Err),   32'd1);
        chk("lock.ack",  32'(bus0.Sel_Ack),   32'd0);
        chk("lock.busy", 32'(bus0.Sel_Busy),  32'd0);
        chk("lock.val",  32'(bus0.Out_Valid), 32'd1);
        // Locked same-select is rejected too.
        bus0.Sel_In = 2'd0;
        tick();
        bus0.Sel_Req = 1'b0;
        chk("lock.same_err", 32'(bus0.Sel_Err), 32'd1);
        chk("lock.same_ack", 32'(bus0.Sel_Ack), 32'd0);
        tick();
        chk("lock.cur", 32'(bus0.Cur_Sel), 32'd0);
        chk("lock.out", 32'(bus0.Mux_Out), 32'hA5);
        bus0.Sel_Lock = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_nx1_switch.md
Name: mux_nx1_switch

Overview:
- Parametrised N-to-1, WIDTH-bit registered multiplexer with glitch-safe select switching. It is the successor to the 2:1 function/test-mode mux.
- Select changes go through a request/acknowledge handshake. A programmable blanking gap drives a defined idle value between the old and new source.
- Used in the system datapath and test-mode routing, where a downstream consumer must never see a mixed or partial source change.

Parameters:
- WIDTH, 8, data width of each channel and of Mux_Out
- CHANNELS, 4, number of input channels (legal range 2..16)
- GAP, 2, blanking cycles between old and new source (legal range 0..15)
- RST_SEL, 0, channel selected out of reset (must be < CHANNELS)
- IDLE_VAL, 0, value driven on Mux_Out while blanking or in reset
- SEL_W (localparam), clog2(CHANNELS), select width

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- Data_In  in  CHANNELS*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH]
- Sel_Req  in  1  single-cycle select-change request
- Sel_In  in  SEL_W  requested channel, sampled when Sel_Req=1
- Sel_Busy  out  1  high while a switch is in progress
- Sel_Ack  out  1  one-cycle pulse when the new select is in effect
- Sel_Err  out  1  one-cycle pulse when a request is rejected
- Cur_Sel  out  SEL_W  channel currently routed
- Mux_Out  out  WIDTH  registered output data
- Out_Valid  out  1  high when Mux_Out carries channel data

Behaviour:
- Reset (RST=1 at a CLK edge, from any state):
  - Cur_Sel=RST_SEL, Mux_Out=IDLE_VAL, Out_Valid=0.
  - Sel_Busy=0, Sel_Ack=0, Sel_Err=0.
  - FSM goes to ACTIVE; gap counter is cleared.
  - Any pending request is discarded.
- First cycle after reset release: Mux_Out shows Data_In[RST_SEL] and Out_Valid=1.
- FSM states:
  - ACTIVE: Mux_Out <= Data_In[Cur_Sel] every cycle, so latency is 1 cycle. Out_Valid=1.
  - BLANK: Mux_Out <= IDLE_VAL, Out_Valid=0, Sel_Busy=1. The gap counter counts down from GAP-1.
  - SWITCH: one cycle. Cur_Sel <= pending select, Sel_Ack=1, Sel_Busy=1, Mux_Out <= IDLE_VAL. Then go to ACTIVE.
- Request handling in ACTIVE when Sel_Req=1:
  - Sel_In >= CHANNELS: rejected. Sel_Err pulses the next cycle. No state change and no output disturbance.
  - Sel_In == Cur_Sel: Sel_Ack pulses the next cycle. No blanking and no gap in Out_Valid.
  - Otherwise: latch Sel_In as pending. Go to BLANK if GAP>0, else go directly to SWITCH.
- A request accepted at edge t:
  - Out_Valid is 0 for cycles t+1 .. t+GAP+1.
  - Sel_Ack pulses in cycle t+GAP+1.
  - New-channel data appears in cycle t+GAP+2.
- Sel_Req while Sel_Busy=1: ignored. No Err and no Ack; it is not queued.
- Sel_Req and RST asserted in the same cycle: reset wins.
- Sel_Ack and Sel_Err are never high in the same cycle.
- Cur_Sel changes only in SWITCH or on reset.

Optional Feature:
- Macro: MUX_SEL_LOCK_EN
- With the macro defined:
  - An extra input port Sel_Lock (1 bit) is added.
  - While Sel_Lock=1 in ACTIVE, every Sel_Req is rejected with a Sel_Err pulse, including Sel_In == Cur_Sel.
  - A switch already in BLANK/SWITCH completes regardless of Sel_Lock.
- Without the macro: no Sel_Lock port; behaviour is exactly as above.

Decomposition:
- Package mux_switch_pkg holds:
  - state encoding (ACTIVE=2'd0, BLANK=2'd1, SWITCH=2'd2)
  - gap counter width constant (4 bits)
  - clog2 helper function
- One sub-module, mux_nx1_core: purely combinational WIDTH x CHANNELS selector, indexed by Cur_Sel, instantiated once. The FSM, counter and output register stay in mux_nx1_switch.

Test Plan:
- Reset and pass-through (defaults):
  - Stimulus: RST high 2 cycles, then Data_In channel 0 = 8'hA5.
  - Response: during reset Mux_Out=8'h00 and Out_Valid=0. One cycle after release Mux_Out=8'hA5, Out_Valid=1, Cur_Sel=0.
- Normal switch, GAP=2:
  - Stimulus: Sel_Req with Sel_In=3, channel 3 = 8'h3C.
  - Response: Out_Valid low 3 cycles with Mux_Out=8'h00. Sel_Ack pulses in the 3rd cycle. The 4th cycle shows Mux_Out=8'h3C and Cur_Sel=3.
- Same-select and out-of-range requests, CHANNELS=3:
  - Sel_In == Cur_Sel: Sel_Ack next cycle, Out_Valid stays 1.
  - Sel_In=3: Sel_Err next cycle, Cur_Sel unchanged.
- Request during busy:
  - Stimulus: second Sel_Req (Sel_In=1) while blanking toward channel 2.
  - Response: ignored. Final Cur_Sel=2, exactly one Sel_Ack.
- Reset mid-switch:
  - Stimulus: RST asserted in the 1st BLANK cycle.
  - Response: Cur_Sel=RST_SEL, Sel_Ack never pulses, normal pass-through resumes.
- GAP=0 build and MUX_SEL_LOCK_EN build:
  - GAP=0: a switch shows exactly 1 cycle of Out_Valid=0.
  - MUX_SEL_LOCK_EN: with Sel_Lock=1, a Sel_Req to channel 1 gives Sel_Err and no switch.
